// File: rtl/mem_seq_gen.sv
// Programmable memory-command sequencer: emits addr/wr/en/wdata transactions
// from base/stride/count/seed, with ready backpressure and a done pulse.
module mem_seq_gen #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] seed,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic              en,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StWph, StRph, StIlv, StFin} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                en_q, en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last;

    assign last  = (idx_q == count_q - CNT_W'(1));
    assign addr  = addr_q;
    assign wr    = wr_q;
    assign en    = en_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            en_q     <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            en_q     <= en_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        stride_d = stride_q;
        count_d  = count_q;
        idx_d    = idx_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        en_d     = en_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    mode_d   = mode;
                    base_d   = base_addr;
                    stride_d = stride;
                    count_d  = count;
                    data_d   = seed;
                    idx_d    = '0;
                    addr_d   = base_addr;
                    if (count == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        en_d   = 1'b1;
                        busy_d = 1'b1;
                        case (mode)
                            2'b01: begin
                                state_d = StRph;
                                wr_d    = 1'b0;
                                wdata_d = '0;
                            end
                            2'b11: begin
                                state_d = StIlv;
                                wr_d    = 1'b1;
                                wdata_d = seed;
                            end
                            default: begin
                                state_d = StWph;
                                wr_d    = 1'b1;
                                wdata_d = seed;
                            end
                        endcase
                    end
                end
            end

            StWph: begin
                if (ready) begin
                    if (!last) begin
                        idx_d   = idx_q + CNT_W'(1);
                        addr_d  = addr_q + stride_q;
                        data_d  = data_q + DATA_W'(1);
                        wdata_d = data_q + DATA_W'(1);
                    end else if (mode_q == 2'b10) begin
                        // Read phase replays the same addresses with no gap cycle
                        state_d = StRph;
                        idx_d   = '0;
                        addr_d  = base_q;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end else begin
                        state_d = StFin;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end

            StRph: begin
                if (ready) begin
                    if (!last) begin
                        idx_d  = idx_q + CNT_W'(1);
                        addr_d = addr_q + stride_q;
                    end else begin
                        state_d = StFin;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            StIlv: begin
                if (ready) begin
                    if (wr_q) begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end else if (!last) begin
                        idx_d   = idx_q + CNT_W'(1);
                        addr_d  = addr_q + stride_q;
                        data_d  = data_q + DATA_W'(1);
                        wr_d    = 1'b1;
                        wdata_d = data_q + DATA_W'(1);
                    end else begin
                        state_d = StFin;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/mem_seq_gen.md
# mem_seq_gen

Parametrised memory-command sequencer that drives `addr`/`wr`/`en`/`wdata` transactions into a single-port memory or register-file DUT. It replaces hand-written per-cycle stimulus with a programmable generator: base address, stride, count, data seed and access mode. A single `start` launches a run, and a `ready` input supplies backpressure. It sits between test/control logic and the memory port, is synthesisable, and is reused in benches and in on-chip self-test.

## Interface
- `ADDR_W`, default 6: address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 8: write-data width.
- `CNT_W`, default 6: width of the transaction-count field.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  launches a run; sampled only while `busy`=0.
- `mode`  in  2  access mode: 00 write-only, 01 read-only, 10 write-then-read, 11 interleaved.
- `base_addr`  in  ADDR_W  address of index 0.
- `stride`  in  ADDR_W  address increment per index.
- `count`  in  CNT_W  number of indices; 0 means an empty run.
- `seed`  in  DATA_W  write data for index 0.
- `ready`  in  1  downstream accepts the current transaction.
- `addr`  out  ADDR_W  transaction address.
- `wr`  out  1  1 = write, 0 = read.
- `en`  out  1  transaction valid.
- `wdata`  out  DATA_W  write data; 0 during reads.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, WPH (write phase), RPH (read phase), ILV (interleaved), FIN.
- Latching: `mode`, `base_addr`, `stride`, `count` and `seed` are latched on the edge that accepts `start`. Later changes to these inputs have no effect on the run.
- Address and data for index i: addr = (base_addr + i*stride) mod 2^ADDR_W; write data = (seed + i) mod 2^DATA_W. Both are computed incrementally by accumulators, with no multiplier.
- Mode 00: WPH only, i = 0..count-1, `wr`=1.
- Mode 01: RPH only, i = 0..count-1, `wr`=0.
- Mode 10: WPH for all i, then RPH for the same addresses in the same order. There is no idle cycle between the phases.
- Mode 11: ILV; for each i, a write then a read to the same address, giving 2*count transactions.
- Handshake: a transaction is accepted on an edge where `en`=1 and `ready`=1. While `en`=1 and `ready`=0, `addr`, `wr` and `wdata` hold stable. `en` stays high back-to-back while transactions remain.
- Run end: on the edge that accepts the last transaction, the block enters FIN: `en`←0, `busy`←0, `done`←1. On the next edge it enters IDLE and `done`←0.
- `start` in FIN is accepted, because `busy`=0. `start` while `busy`=1 is ignored and has no side effects.
- `count`=0: the accepting edge goes straight to FIN. `en` never asserts, and `done` pulses for one cycle.

## Timing
- All outputs are registered.
- Reset values: `addr`=0, `wr`=0, `en`=0, `wdata`=0, `busy`=0, `done`=0; state is IDLE.
- `rst_n`=0 sampled at any edge, including mid-run, forces the reset values at that edge. Any in-flight transaction is dropped, not completed.
- Latency: the edge that samples `start`=1 also drives the first transaction, so `en`=1 and `busy`=1 are visible in the following cycle.
- With `ready` held high, a run of N transactions has `en` high for exactly N consecutive cycles. `done` is high in the cycle immediately after the last `en` cycle.
- Each `ready`=0 cycle during `en`=1 extends the run by one cycle.
- `ready` is ignored while `en`=0.
- Wrap-around: the address accumulator overflows silently modulo 2^ADDR_W. The data accumulator overflows silently modulo 2^DATA_W. Neither raises an error.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles after arbitrary activity. Required: all outputs 0. Then assert `start` with `count`=0. Required: `done`=1 for exactly one cycle and `en` never high.
- Write-only: mode 00, base 12, stride 2, count 3, seed 8'hA0, `ready`=1. Required: three consecutive `en` cycles with addr 12/14/16, `wr`=1, wdata A0/A1/A2, then a `done` pulse.
- Write-then-read with wrap: mode 10, base 60, stride 3, count 3. Required: writes to addr 60, 63, 2, then reads to 60, 63, 2; six contiguous `en` cycles; `wdata`=0 on the reads.
- Backpressure: repeat the write-only case with `ready`=0 for 2 cycles while addr=14. Required: addr=14 and wdata=A1 hold stable; `en` high for 5 cycles total; `done` after addr=16 is accepted.
- Interleaved, and start while busy: mode 11, base 23, stride 25, count 2. Required: sequence W23, R23, W48, R48. A second `start` pulsed while `busy`=1 must leave the sequence unchanged.
- Reset mid-run: drop `rst_n` on the 2nd transaction of a mode-00, count-5 run. Required: all outputs 0 on the next edge. A `start` issued after reset must run a fresh sequence from the new `base_addr`.
